adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and sequencer that shares one `adder` instance (B-bit, carry-skip) among N requesters. Each requester presents an add or subtract operation with a valid/ready handshake. The block grants one requester per accepted transaction, drives the shared adder from that requester's operands, and registers the result into a single response channel that supports backpressure. It sits between the ALU-side clients and the shared adder datapath.

## Interface
- `B`, 32, operand and result width; passed to the internal `adder`.
- `N`, 4, number of requesters; N ≥ 2.
- `IDW`, 2, requester-index width; must equal clog2(N).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  N  bit i: requester i has an operation pending.
- `req_ready`  out  N  bit i: requester i is accepted this cycle; at most one bit high.
- `req_a`  in  N*B  operand A; requester i occupies bits [i*B +: B].
- `req_b`  in  N*B  operand B; same packing as `req_a`.
- `req_cin`  in  N  carry-in per requester; ignored when the matching `req_sub` bit is 1.
- `req_sub`  in  N  1 selects subtract (a − b); 0 selects add (a + b + cin).
- `resp_valid`  out  1  response register holds a result.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  IDW  index of the requester that produced the result.
- `resp_sum`  out  B  sum, or difference, mod 2^B.
- `resp_cout`  out  1  carry-out; for subtract, 1 means no borrow (a ≥ b unsigned).

## Operation
- Exactly one `adder #(B)` instance. Its inputs are muxed combinationally from the granted requester:
  - add: a, b, cin.
  - subtract: a, ~b, 1.
- Two states:
  - IDLE: `resp_valid` = 0.
  - HOLD: `resp_valid` = 1.
- `slot_free` = (state == IDLE) | (state == HOLD & `resp_ready`).
- Grant g = first i with `req_valid[i]` = 1, searching cyclically from `ptr` (`ptr`, `ptr`+1, …, wrapping mod N).
- `req_ready[g]` = `slot_free` & any `req_valid`. All other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`, `ptr`, state and `resp_ready`.
- Accept = `req_valid[g]` & `req_ready[g]`. On accept:
  - `resp_sum`, `resp_cout` ← adder outputs.
  - `resp_id` ← g.
  - `ptr` ← (g+1) mod N.
  - state ← HOLD.
- HOLD with `resp_ready` = 1 and no accept: state ← IDLE.
- HOLD with `resp_ready` = 1 and an accept in the same cycle: state stays HOLD with the new result (back-to-back, one result per cycle).
- HOLD with `resp_ready` = 0: all response outputs hold their values and `req_ready` = 0.
- Requesters keep operands stable and keep valid high until accepted. Behaviour when valid drops before acceptance is legal but undefined for fairness.
- `ptr` changes only on accept. A requester that withdraws does not move the pointer.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, `ptr` = 0.
  - `resp_valid` = 0, `resp_sum` = 0, `resp_cout` = 0, `resp_id` = 0.
  - `req_ready` = 0 while in reset.
- Reset asserted in HOLD discards the pending result. Nothing is replayed.
- Latency: accept on edge k, then `resp_valid` = 1 with the result after edge k (one cycle).
- Throughput: one operation per cycle while `resp_ready` stays 1.
- Fairness: with all N valid continuously, grants rotate 0,1,…,N−1,0. Each requester waits at most N−1 grants.
- The adder path plus the grant mux is a single-cycle combinational path from request inputs to the result register.

## Test plan
- Reset then single add:
  - Stimulus: requester 2 with a=0x0000_0005, b=0x0000_0003, cin=1, sub=0.
  - Response: `req_ready` = 0100 the same cycle; next cycle `resp_valid` = 1, `resp_id` = 2, `resp_sum` = 0x9, `resp_cout` = 0.
- Subtract and borrow:
  - Requester 0, a=3, b=5, sub=1: `resp_sum` = 0xFFFF_FFFE, `resp_cout` = 0.
  - a=5, b=3: `resp_sum` = 2, `resp_cout` = 1.
  - Carry-out: add a=0xFFFF_FFFF, b=1, cin=0 gives `resp_sum` = 0, `resp_cout` = 1.
- Round-robin:
  - Stimulus: all 4 valid continuously, `resp_ready` = 1.
  - Response: `resp_id` sequence 0,1,2,3,0 on consecutive cycles, with `resp_valid` never dropping.
- Backpressure:
  - Stimulus: `resp_ready` = 0 for 5 cycles after the first result.
  - Response: `resp_sum`/`resp_id` stable and `req_ready` = 0 throughout. Raising `resp_ready` with requester 1 valid gives accept in that cycle and the new result next cycle.
- Pointer skip:
  - Stimulus: `ptr` = 1 (after a grant to 0), only requesters 0 and 3 valid.
  - Response: grant to 3 then 0.
- Mid-operation reset:
  - Stimulus: assert `rst_n` low in HOLD between clock edges.
  - Response: `resp_valid` falls immediately. After release the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one carry-skip adder among N requesters,
// with a single registered response channel that supports backpressure.

module adder #(
    parameter int B = 32,
    parameter int K = 4
) (
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    input  logic         cin,
    output logic [B-1:0] sum,
    output logic         cout
);
    localparam int NB = (B + K - 1) / K;
    localparam int W  = NB * K;
    logic [W-1:0] ap, bp, p, g;
    logic [W:0]   c;
    assign ap = W'(a);
    assign bp = W'(b);
    assign p  = ap ^ bp;
    assign g  = ap & bp;
    // Ripple inside each K-bit block; a fully propagating block forwards its carry-in directly.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < K; i++)
                c[j*K+i+1] = g[j*K+i] | (p[j*K+i] & c[j*K+i]);
            if (&p[j*K +: K])
                c[j*K+K] = c[j*K];
        end
    end
    assign sum  = p[B-1:0] ^ c[B-1:0];
    assign cout = c[B];
endmodule

module adder_arbiter #(
    parameter int B   = 32,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*B-1:0] req_a,
    input  logic [N*B-1:0] req_b,
    input  logic [N-1:0]   req_cin,
    input  logic [N-1:0]   req_sub,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [IDW-1:0] resp_id,
    output logic [B-1:0]   resp_sum,
    output logic           resp_cout
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] ptr, grant, idx;
    logic           found, slot_free, accept, add_cout;
    logic [B-1:0]   add_a, add_b, add_sum;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign slot_free = (state == IDLE) | resp_ready;
    assign accept    = rst_n & slot_free & found;
    assign req_ready = accept ? (N'(1) << grant) : '0;

    assign add_a = req_a[grant*B +: B];
    assign add_b = req_sub[grant] ? ~req_b[grant*B +: B] : req_b[grant*B +: B];

    adder #(.B(B)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (req_sub[grant] | req_cin[grant]),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            resp_sum  <= '0;
            resp_cout <= 1'b0;
            resp_id   <= '0;
        end else if (accept) begin
            state     <= HOLD;
            ptr       <= (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
            resp_sum  <= add_sum;
            resp_cout <= add_cout;
            resp_id   <= grant;
        end else if (resp_ready) begin
            state <= IDLE;
        end
    end

    assign resp_valid = (state == HOLD);
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors with hand-computed results for adder_arbiter.

module tb_adder_arbiter;
    localparam int B = 32, N = 4, IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_cin, req_sub;
    logic [N*B-1:0] req_a, req_b;
    logic           resp_valid, resp_ready, resp_cout;
    logic [IDW-1:0] resp_id;
    logic [B-1:0]   resp_sum;
    int             n_cmp = 0, n_err = 0;

    adder_arbiter #(.B(B), .N(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_sum(resp_sum), .resp_cout(resp_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int i, input logic [B-1:0] a, input logic [B-1:0] b,
                       input logic cin, input logic sub);
        req_a[i*B +: B] = a;
        req_b[i*B +: B] = b;
        req_cin[i]      = cin;
        req_sub[i]      = sub;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string tag, input logic [IDW-1:0] id,
                               input logic [B-1:0] sum, input logic cout);
        check({tag, "_valid"}, resp_valid, 1);
        check({tag, "_id"}, resp_id, id);
        check({tag, "_sum"}, resp_sum, sum);
        check({tag, "_cout"}, resp_cout, cout);
    endtask

    initial begin
        rst_n = 1'b0; resp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = '0; req_sub = '0;
        req_valid = 4'b1111;
        #12;
        check("rst_valid", resp_valid, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_cout", resp_cout, 0);
        check("rst_id", resp_id, 0);
        check("rst_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk) rst_n = 1'b1;

        // single add: 5 + 3 + 1
        step;
        put(2, 32'd5, 32'd3, 1'b1, 1'b0);
        req_valid = 4'b0100;
        #1 check("add_ready", req_ready, 4'b0100);
        step;
        expect_resp("add", 2, 32'h9, 0);

        // subtract with and without borrow, then add carry-out
        put(0, 32'd3, 32'd5, 1'b1, 1'b1);
        req_valid = 4'b0001;
        step;
        expect_resp("sub_borrow", 0, 32'hFFFF_FFFE, 0);
        put(0, 32'd5, 32'd3, 1'b0, 1'b1);
        step;
        expect_resp("sub_ok", 0, 32'h2, 1);
        put(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step;
        expect_resp("carry", 0, 32'h0, 1);
        req_valid = '0;
        step;
        check("idle_valid", resp_valid, 0);

        // steer pointer to 0 via requester 3, then full rotation
        for (int i = 0; i < N; i++) put(i, 32'(16 * i + 1), 32'(i), 1'b0, 1'b0);
        req_valid = 4'b1000;
        step;
        expect_resp("pre_rr", 3, 32'd52, 0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step;
            expect_resp($sformatf("rr%0d", k), IDW'(k % N), 32'(17 * (k % N) + 1), 0);
        end

        // backpressure holds the response and blocks all grants
        resp_ready = 1'b0;
        put(1, 32'd100, 32'd23, 1'b0, 1'b0);
        req_valid = 4'b0010;
        #1 check("bp_ready0", req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step;
            expect_resp($sformatf("bp%0d", k), 0, 32'd1, 0);
            check($sformatf("bp%0d_ready", k), req_ready, 0);
        end
        resp_ready = 1'b1;
        #1 check("bp_release_ready", req_ready, 4'b0010);
        step;
        expect_resp("bp_new", 1, 32'd123, 0);

        // pointer skip: ptr=1 after grant to 0, only 0 and 3 valid
        req_valid = 4'b0001;
        step;
        expect_resp("skip_pre", 0, 32'd1, 0);
        req_valid = 4'b1001;
        #1 check("skip_ready3", req_ready, 4'b1000);
        step;
        expect_resp("skip3", 3, 32'd52, 0);
        req_valid = 4'b0001;
        #1 check("skip_ready0", req_ready, 4'b0001);
        step;
        expect_resp("skip0", 0, 32'd1, 0);

        // asynchronous reset while holding a result
        req_valid = 4'b0100;
        step;
        expect_resp("mid_pre", 2, 32'd35, 0);
        req_valid = 4'b1010;
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid", resp_valid, 0);
        check("mid_sum", resp_sum, 0);
        check("mid_id", resp_id, 0);
        check("mid_ready", req_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_rst_ready", req_ready, 4'b0010);
        step;
        expect_resp("post_rst", 1, 32'd123, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
